// File: rtl/address_window_map.sv
// Table-driven SNES address window mapper: N_WIN programmable windows, double-buffered config,
// 2-stage registered lookup with sticky write-violation flag.
module address_window_map #(
    parameter int unsigned N_WIN  = 4,
    parameter int unsigned CFG_AW = $clog2(N_WIN) + 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic [23:0]       SNES_ADDR,
    input  logic              SNES_WR,
    input  logic              CFG_WE,
    input  logic [CFG_AW-1:0] CFG_ADDR,
    input  logic [7:0]        CFG_DATA,
    input  logic              CFG_COMMIT,
    input  logic              VIOL_CLR,
    output logic              VALID,
    output logic [23:0]       MAPPED_ADDR,
    output logic              HIT,
    output logic [3:0]        WIN_IDX,
    output logic              SRAM1_SEL,
    output logic              IS_WRITABLE,
    output logic              WR_VIOLATION
);

    localparam int unsigned WIN_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;

    logic [7:0] shadow_q [N_WIN][8];
    logic [7:0] shadow_d [N_WIN][8];
    logic [7:0] active_q [N_WIN][8];

    logic [CFG_AW-1:0] cfg_win_full;
    logic [WIN_W-1:0]  cfg_win;

    // Shadow next-state includes the byte written this cycle so a same-cycle commit sees it.
    always_comb begin
        shadow_d     = shadow_q;
        cfg_win_full = CFG_ADDR >> 3;
        cfg_win      = cfg_win_full[WIN_W-1:0];
        if (CFG_WE && (cfg_win_full < CFG_AW'(N_WIN))) begin
            shadow_d[cfg_win][CFG_ADDR[2:0]] = CFG_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_WIN; i++) begin
                for (int b = 0; b < 8; b++) begin
                    shadow_q[i][b] <= 8'h00;
                    active_q[i][b] <= 8'h00;
                end
            end
        end else begin
            shadow_q <= shadow_d;
            if (CFG_COMMIT) begin
                active_q <= shadow_d;
            end
        end
    end

    // Stage 1: match vector plus a snapshot of each window's translation fields, so a commit
    // landing while the lookup sits in stage 2 cannot mix tables.
    logic [N_WIN-1:0] match_d;
    logic [N_WIN-1:0] s1_match_q;
    logic [23:0]      s1_base_q [N_WIN];
    logic [7:0]       s1_ctrl_q [N_WIN];
    logic             s1_valid_q;
    logic [23:0]      s1_addr_q;
    logic             s1_wr_q;

    always_comb begin
        match_d = '0;
        for (int i = 0; i < N_WIN; i++) begin
            match_d[i] = (((SNES_ADDR[23:16] ^ active_q[i][0]) & active_q[i][1]) == 8'h00)
                      && (((SNES_ADDR[15:8] ^ active_q[i][2]) & active_q[i][3]) == 8'h00)
                      && (active_q[i][7][4:0] != 5'd0);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= 24'h0;
            s1_wr_q    <= 1'b0;
            s1_match_q <= '0;
            for (int i = 0; i < N_WIN; i++) begin
                s1_base_q[i] <= 24'h0;
                s1_ctrl_q[i] <= 8'h00;
            end
        end else begin
            s1_valid_q <= REQ;
            if (REQ) begin
                s1_addr_q  <= SNES_ADDR;
                s1_wr_q    <= SNES_WR;
                s1_match_q <= match_d;
                for (int i = 0; i < N_WIN; i++) begin
                    s1_base_q[i] <= {active_q[i][6], active_q[i][5], active_q[i][4]};
                    s1_ctrl_q[i] <= active_q[i][7];
                end
            end
        end
    end

    // Stage 2: priority encode (lowest index wins) and translate.
    logic        hit_d;
    logic [3:0]  idx_d;
    logic [23:0] sel_base;
    logic [7:0]  sel_ctrl;
    logic [4:0]  size_eff;
    logic [23:0] wmask;
    logic [23:0] eff_addr;
    logic [23:0] mapped_d;
    logic        viol_set;
    logic        viol_d;

    always_comb begin
        hit_d    = 1'b0;
        idx_d    = 4'd0;
        sel_base = 24'h0;
        sel_ctrl = 8'h00;
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if (s1_match_q[i]) begin
                hit_d    = 1'b1;
                idx_d    = 4'(i);
                sel_base = s1_base_q[i];
                sel_ctrl = s1_ctrl_q[i];
            end
        end
        size_eff = (sel_ctrl[4:0] > 5'd24) ? 5'd24 : sel_ctrl[4:0];
        wmask    = 24'((25'd1 << size_eff) - 25'd1);
        eff_addr = sel_ctrl[5] ? {1'b0, s1_addr_q[23:16], s1_addr_q[14:0]} : s1_addr_q;
        mapped_d = hit_d ? ((sel_base & ~wmask) | (eff_addr & wmask)) : s1_addr_q;
        viol_set = s1_valid_q && s1_wr_q && hit_d && !sel_ctrl[7];
        viol_d   = viol_set ? 1'b1 : (VIOL_CLR ? 1'b0 : WR_VIOLATION);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            VALID        <= 1'b0;
            MAPPED_ADDR  <= 24'h0;
            HIT          <= 1'b0;
            WIN_IDX      <= 4'd0;
            SRAM1_SEL    <= 1'b0;
            IS_WRITABLE  <= 1'b0;
            WR_VIOLATION <= 1'b0;
        end else begin
            VALID        <= s1_valid_q;
            WR_VIOLATION <= viol_d;
            if (s1_valid_q) begin
                MAPPED_ADDR <= mapped_d;
                HIT         <= hit_d;
                WIN_IDX     <= idx_d;
                SRAM1_SEL   <= hit_d & sel_ctrl[6];
                IS_WRITABLE <= hit_d & sel_ctrl[7];
            end
        end
    end

endmodule
